// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with occupancy count, almost flags,
// synchronous flush and registered overflow/underflow pulses with sticky status.
module param_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow,
    output logic [1:0]       err_sticky
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d, overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [1:0]       err_q, err_d;
    logic             rd_acc, wr_acc;

    // Flags decode the registered count only, so they never see write_en/read_en.
    assign full         = count_q == (AW+1)'(DEPTH);
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= (AW+1)'(AF_THRESH);
    assign almost_empty = count_q <= (AW+1)'(AE_THRESH);
    assign count        = count_q;
    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign err_sticky   = err_q;

    assign rd_acc = read_en && !empty && !flush;
    assign wr_acc = write_en && (!full || rd_acc) && !flush;

    always_comb begin
        overflow_d   = write_en && !wr_acc && !flush;
        underflow_d  = read_en && !rd_acc && !flush;
        err_d        = flush ? 2'b00 : err_q | {overflow_d, underflow_d};
        wr_ptr_d     = flush ? '0 : wr_ptr_q + (AW+1)'(wr_acc);
        rd_ptr_d     = flush ? '0 : rd_ptr_q + (AW+1)'(rd_acc);
        count_d      = flush ? '0 : count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        data_out_d   = flush ? '0 : rd_acc ? mem_q[rd_ptr_q[AW-1:0]] : data_out_q;
        data_valid_d = rd_acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            err_q        <= 2'b00;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            err_q        <= err_d;
        end
    end

    // Storage is neither reset nor flushed; only the pointers are.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed self-checking bench for param_fifo at the default
// 8-bit x 16 configuration.
module tb_param_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1, flush = 1'b0, write_en = 1'b0, read_en = 1'b0;
    logic [7:0] data_in = 8'h00, data_out;
    logic       data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;
    logic [1:0] err_sticky;
    int         n_cmp = 0, n_bad = 0;

    param_fifo dut (
        .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .data_out(data_out), .data_valid(data_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r);
        write_en = w;
        data_in  = d;
        read_en  = r;
    endtask

    initial begin
        step;
        step;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_err", err_sticky, 0);
        reset = 1'b0;
        // fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            drive(1, 8'(i), 0);
            step;
            chk("fill_count", count, i);
            chk("fill_af", almost_full, i >= 12);
            chk("fill_ae", almost_empty, i <= 2);
        end
        chk("fill_full", full, 1);
        chk("fill_empty", empty, 0);
        drive(1, 8'hAA, 0);
        step;
        chk("ovf_pulse", overflow, 1);
        chk("ovf_err", err_sticky, 2'b10);
        chk("ovf_count", count, 16);
        drive(0, 0, 0);
        step;
        chk("ovf_clear", overflow, 0);
        chk("ovf_err_hold", err_sticky, 2'b10);
        for (int i = 1; i <= 16; i++) begin
            drive(0, 0, 1);
            step;
            chk("drain_data", data_out, i);
            chk("drain_valid", data_valid, 1);
            chk("drain_count", count, 16 - i);
        end
        chk("drain_empty", empty, 1);
        // underflow on empty
        drive(0, 0, 1);
        step;
        chk("udf_pulse", underflow, 1);
        chk("udf_err", err_sticky, 2'b11);
        chk("udf_dout_hold", data_out, 8'h10);
        chk("udf_valid", data_valid, 0);
        // simultaneous read+write at empty
        drive(1, 8'h77, 1);
        step;
        chk("emp_rw_udf", underflow, 1);
        chk("emp_rw_count", count, 1);
        chk("emp_rw_valid", data_valid, 0);
        drive(0, 0, 1);
        step;
        chk("emp_rw_data", data_out, 8'h77);
        chk("emp_rw_udf_clr", underflow, 0);
        chk("emp_rw_cnt0", count, 0);
        // 40-word stream, reader one cycle behind
        drive(1, 8'h80, 0);
        step;
        for (int k = 1; k < 40; k++) begin
            drive(1, 8'(8'h80 + k), 1);
            step;
            chk("strm_data", data_out, 8'(8'h80 + k - 1));
            chk("strm_valid", data_valid, 1);
            chk("strm_count", count, 1);
        end
        drive(0, 0, 1);
        step;
        chk("strm_last", data_out, 8'hA7);
        chk("strm_cnt0", count, 0);
        // refill then read+write while full
        for (int i = 0; i < 16; i++) begin
            drive(1, 8'(8'h30 + i), 0);
            step;
        end
        chk("refill_full", full, 1);
        drive(1, 8'hEE, 1);
        step;
        chk("full_rw_count", count, 16);
        chk("full_rw_ovf", overflow, 0);
        chk("full_rw_data", data_out, 8'h30);
        chk("full_rw_valid", data_valid, 1);
        for (int i = 0; i < 11; i++) begin
            drive(0, 0, 1);
            step;
        end
        chk("pre_flush_data", data_out, 8'h3B);
        chk("pre_flush_count", count, 5);
        // flush with a concurrent write
        flush = 1'b1;
        drive(1, 8'h99, 0);
        step;
        flush = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_err", err_sticky, 0);
        chk("flush_dout", data_out, 0);
        chk("flush_ovf", overflow, 0);
        drive(1, 8'h42, 0);
        step;
        chk("post_flush_count", count, 1);
        drive(0, 0, 1);
        step;
        chk("post_flush_data", data_out, 8'h42);
        chk("post_flush_valid", data_valid, 1);
        // async reset at count 9, with some error status pending
        drive(0, 0, 1);
        step;
        chk("pre_rst_err", err_sticky, 2'b01);
        for (int i = 0; i < 9; i++) begin
            drive(1, 8'(8'h60 + i), 0);
            step;
        end
        drive(0, 0, 0);
        chk("pre_rst_count", count, 9);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_ae", almost_empty, 1);
        chk("arst_err", err_sticky, 0);
        chk("arst_dout", data_out, 0);
        chk("arst_valid", data_valid, 0);
        reset = 1'b0;
        drive(1, 8'h55, 0);
        step;
        drive(0, 0, 1);
        step;
        chk("arst_after_data", data_out, 8'h55);
        chk("arst_after_valid", data_valid, 1);
        drive(0, 0, 0);
        step;
        chk("valid_drop", data_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/param_fifo.md
# param_fifo

Parametrised single-clock FIFO that buffers words between a producer writing with `write_en` and a consumer reading with `read_en`. It supersedes the fixed 8-bit FIFO and its separate input/output control units with one self-contained block. The block adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and registered overflow/underflow pulses with sticky error status.

## Interface
Parameters:
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 16: number of entries; must be a power of 2 and at least 4.
- `AF_THRESH`, 12: `almost_full` asserts when count ≥ `AF_THRESH`; range 1..DEPTH.
- `AE_THRESH`, 2: `almost_empty` asserts when count ≤ `AE_THRESH`; range 0..DEPTH-1.
- Derived: `AW` = $clog2(DEPTH).

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `flush` input 1: synchronous clear; highest priority.
- `write_en` input 1: write request.
- `data_in` input WIDTH: write data.
- `read_en` input 1: read request.
- `data_out` output WIDTH: registered read data.
- `data_valid` output 1: one-cycle pulse; `data_out` holds a newly popped word.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `almost_full` output 1: count ≥ AF_THRESH.
- `almost_empty` output 1: count ≤ AE_THRESH.
- `count` output AW+1: current occupancy, 0..DEPTH.
- `overflow` output 1: one-cycle pulse; a write was dropped.
- `underflow` output 1: one-cycle pulse; a read was rejected.
- `err_sticky` output 2: bit0 = underflow seen, bit1 = overflow seen; cleared only by `reset` or `flush`.

## Operation
- Storage is a DEPTH×WIDTH register array.
- Write and read pointers are each AW+1 bits. The low AW bits address the array; the MSB is a wrap bit.
- Both pointers increment modulo 2^(AW+1), so they wrap naturally at DEPTH.
- `count` is a registered counter: +1 on an accepted write only, −1 on an accepted read only, unchanged when both or neither are accepted.
- Write accepted when `write_en && (!full || read_accepted)`.
- Read accepted when `read_en && !empty`.
- When full, simultaneous read and write: both accepted; count stays DEPTH; no overflow.
- When empty, simultaneous read and write: read rejected and `underflow` pulses; write accepted; count becomes 1.
- When full, write only: data dropped, `overflow` pulses, `err_sticky[1]` set; no pointer or memory change.
- When empty, read only: `underflow` pulses, `err_sticky[0]` set; `data_out` holds its previous value; `data_valid` = 0.
- Accepted read: `data_out` ← mem[rd_ptr] and `data_valid` = 1 on the same edge; otherwise `data_valid` = 0 and `data_out` holds.
- `flush` high at an edge:
  - pointers, count, `err_sticky`, `data_valid`, `overflow` and `underflow` are cleared;
  - `data_out` is cleared to 0;
  - that cycle's read and write requests are ignored and raise no flags;
  - memory contents are not cleared.
- `reset` asserted (at any time, including mid-transfer) forces the same values as flush, without waiting for a clock edge.
- Reset values:
  - 0: `data_out`, `data_valid`, `full`, `count`, `almost_full`, `overflow`, `underflow`, `err_sticky`;
  - 1: `empty`, `almost_empty`.
- `full`, `empty`, `almost_full` and `almost_empty` are decoded from registered count only. They are glitch-free and carry no combinational path from `write_en` or `read_en`.

## Timing
- Write at edge N: `count`, `empty` and the almost flags reflect it after edge N.
- A read may be issued in cycle N+1; its data appears on `data_out` after edge N+1.
- Minimum write-to-`data_out` latency is 2 edges. There is no fall-through.
- Read latency: one edge from an accepted `read_en` to valid `data_out`/`data_valid`.
- Throughput: one write and one read per cycle, sustained, at any occupancy except the rejected cases above.
- `overflow` and `underflow` are asserted for exactly the cycle after the offending edge. Back-to-back offending requests keep them high continuously.
- `err_sticky` sets on the same edge as the pulse and holds.

## Test plan
- **Reset, then fill:** reset, then write 0x01..0x10 on 16 consecutive cycles (DEPTH=16) → after edge 12 `almost_full`=1; after edge 16 `full`=1, `count`=16, `empty`=0.
- **Overflow:** on the full FIFO, write 0xAA → `overflow` high one cycle, `err_sticky`=2'b10, `count`=16. Then read 16 times → `data_out` sequence 0x01..0x10, each with `data_valid`; 0xAA never appears.
- **Underflow with wrap:** on the empty FIFO, read → `underflow` pulse, `err_sticky[0]`=1, `data_out` unchanged. Then stream 40 words with simultaneous read/write one cycle behind → pointers wrap twice; output order matches input with no loss.
- **Simultaneous access at boundaries:** at count=16, assert read+write together → count stays 16, no `overflow`. At count=0, assert read+write together → `underflow` pulse, count=1.
- **Flush mid-stream:** at count=5, assert flush together with `write_en` → count=0, `empty`=1, `err_sticky`=0; the write is not stored. The next write/read pair returns the new word.
- **Asynchronous reset between edges:** assert `reset` between edges at count=9 → all outputs reach their reset values before the next edge. Deassert, write 0x55, read → `data_out`=0x55.
